// File: rtl/bmem_responder_if.sv
// Burst-memory bus between a cache arbiter (master) and a memory responder (slave).
interface bmem_responder_if;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;
  logic        write_complete;

  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid, write_complete
  );

  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid, write_complete
  );
endinterface

// File: rtl/bmem_responder.sv
// On-chip line memory answering bmem line reads (4-beat bursts after a fixed
// latency) and 4-beat line writes committed atomically from a staging buffer.
module bmem_responder #(
  parameter int unsigned MEM_LINES    = 64,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  bmem_responder_if.slave  bus
);
  localparam int unsigned IW       = $clog2(MEM_LINES);
  localparam logic [3:0]  LAT_LOAD = 4'(READ_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_COLLECT, WR_COMMIT} state_t;

  state_t        state, state_next;
  logic [3:0]    lat_cnt, lat_next;
  logic [1:0]    beat, beat_next, stage_slot;
  logic [26:0]   addr_q, addr_next;
  logic          stage_we;
  logic [63:0]   stage [4];
  logic [255:0]  lines [MEM_LINES];
  logic [IW-1:0] rd_idx, wr_idx;
  logic          rd_beat_next;
  logic          unused_offset;

  assign unused_offset  = ^bus.bmem_addr[4:0];
  assign rd_idx         = addr_next[IW-1:0];
  assign wr_idx         = addr_q[IW-1:0];
  assign rd_beat_next   = (state_next == RD_BURST);
  assign bus.bmem_ready = (state == IDLE) || (state == WR_COLLECT);

  always_comb begin
    state_next = state;
    lat_next   = lat_cnt;
    beat_next  = beat;
    addr_next  = addr_q;
    stage_we   = 1'b0;
    stage_slot = beat;
    case (state)
      IDLE: begin
        if (bus.bmem_read) begin
          addr_next = bus.bmem_addr[31:5];
          beat_next = '0;
          if (READ_LATENCY == 1) begin
            state_next = RD_BURST;
          end else begin
            state_next = RD_WAIT;
            lat_next   = LAT_LOAD;
          end
        end else if (bus.bmem_write) begin
          addr_next  = bus.bmem_addr[31:5];
          stage_we   = 1'b1;
          stage_slot = '0;
          beat_next  = 2'd1;
          state_next = WR_COLLECT;
        end
      end
      RD_WAIT: begin
        lat_next = lat_cnt - 4'd1;
        if (lat_next == '0) begin
          state_next = RD_BURST;
          beat_next  = '0;
        end
      end
      RD_BURST: begin
        beat_next = beat + 2'd1;
        if (beat == 2'd3) state_next = IDLE;
      end
      WR_COLLECT: begin
        if (bus.bmem_write) begin
          stage_we  = 1'b1;
          beat_next = beat + 2'd1;
          if (beat == 2'd3) state_next = WR_COMMIT;
        end
      end
      WR_COMMIT: begin
        state_next = IDLE;
        beat_next  = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each beat appears in the
  // same cycle the FSM sits in RD_BURST; ready then re-opens right after beat 3.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      lat_cnt            <= '0;
      beat               <= '0;
      addr_q             <= '0;
      for (int unsigned i = 0; i < 4; i++) stage[i] <= '0;
      bus.bmem_rvalid    <= 1'b0;
      bus.bmem_rdata     <= '0;
      bus.bmem_raddr     <= '0;
      bus.write_complete <= 1'b0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_next;
      beat    <= beat_next;
      addr_q  <= addr_next;
      if (stage_we) stage[stage_slot] <= bus.bmem_wdata;
      bus.bmem_rvalid    <= rd_beat_next;
      bus.bmem_rdata     <= rd_beat_next ? lines[rd_idx][{beat_next, 6'd0} +: 64] : '0;
      bus.bmem_raddr     <= rd_beat_next ? {addr_next, 5'd0} : '0;
      bus.write_complete <= (state_next == WR_COMMIT);
    end
  end

  always_ff @(posedge clk) begin
    if (state == WR_COMMIT) lines[wr_idx] <= {stage[3], stage[2], stage[1], stage[0]};
  end
endmodule

// File: tb/tb_bmem_responder.sv
// Directed bench for bmem_responder: reset, write/read bursts, gaps, aliasing,
// read/write collision and mid-operation reset.
module tb_bmem_responder;
  localparam int unsigned L = 4;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  bmem_responder_if bif ();

  bmem_responder #(.MEM_LINES(64), .READ_LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pre(input int unsigned i, input int unsigned b);
    return 64'hA5A5_0000_0000_0000 | (64'(i) << 8) | 64'(b);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_b2b(input string tag, input logic [31:0] a,
                           input logic [63:0] d0, d1, d2, d3);
    logic [63:0] d [4];
    d = '{d0, d1, d2, d3};
    bif.bmem_write = 1'b1;
    bif.bmem_addr  = a;
    bif.bmem_wdata = d[0];
    check({tag, ".ready0"}, 64'(bif.bmem_ready), 64'd1);
    tick;
    for (int b = 1; b < 4; b++) begin
      bif.bmem_wdata = d[b];
      bif.bmem_addr  = 32'hFFFF_FFE0;
      check({tag, ".ready_collect"}, 64'(bif.bmem_ready), 64'd1);
      check({tag, ".wc_early"}, 64'(bif.write_complete), 64'd0);
      tick;
    end
    bif.bmem_write = 1'b0;
    bif.bmem_addr  = '0;
    check({tag, ".wc_pulse"}, 64'(bif.write_complete), 64'd1);
    check({tag, ".ready_commit"}, 64'(bif.bmem_ready), 64'd0);
    tick;
    check({tag, ".wc_clear"}, 64'(bif.write_complete), 64'd0);
    check({tag, ".ready_back"}, 64'(bif.bmem_ready), 64'd1);
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic wr,
                            input logic [31:0] eraddr, input logic [63:0] e0, e1, e2, e3);
    logic [63:0] e [4];
    e = '{e0, e1, e2, e3};
    bif.bmem_read  = 1'b1;
    bif.bmem_write = wr;
    bif.bmem_addr  = a;
    bif.bmem_wdata = 64'hDEAD_BEEF_0000_0001;
    check({tag, ".ready_accept"}, 64'(bif.bmem_ready), 64'd1);
    tick;
    bif.bmem_read  = 1'b0;
    bif.bmem_write = 1'b0;
    bif.bmem_addr  = 32'h1234_5660;
    for (int k = 1; k < int'(L); k++) begin
      check({tag, ".rvalid_wait"}, 64'(bif.bmem_rvalid), 64'd0);
      check({tag, ".ready_wait"}, 64'(bif.bmem_ready), 64'd0);
      tick;
    end
    for (int b = 0; b < 4; b++) begin
      check({tag, ".rvalid"}, 64'(bif.bmem_rvalid), 64'd1);
      check({tag, ".rdata"}, bif.bmem_rdata, e[b]);
      check({tag, ".raddr"}, 64'(bif.bmem_raddr), 64'(eraddr));
      check({tag, ".wc_none"}, 64'(bif.write_complete), 64'd0);
      check({tag, ".ready_burst"}, 64'(bif.bmem_ready), 64'd0);
      tick;
    end
    check({tag, ".rvalid_end"}, 64'(bif.bmem_rvalid), 64'd0);
    check({tag, ".ready_end"}, 64'(bif.bmem_ready), 64'd1);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst            = 1'b0;
    bif.bmem_addr  = '0;
    bif.bmem_read  = 1'b0;
    bif.bmem_write = 1'b0;
    bif.bmem_wdata = '0;
    for (int i = 0; i < 64; i++)
      dut.lines[i] = {pre(i, 3), pre(i, 2), pre(i, 1), pre(i, 0)};
    tick;
    tick;
    check("rst.ready", 64'(bif.bmem_ready), 64'd1);
    check("rst.rvalid", 64'(bif.bmem_rvalid), 64'd0);
    check("rst.rdata", bif.bmem_rdata, 64'd0);
    check("rst.raddr", 64'(bif.bmem_raddr), 64'd0);
    check("rst.wc", 64'(bif.write_complete), 64'd0);
    rst = 1'b1;
    tick;
    check("rel.ready", 64'(bif.bmem_ready), 64'd1);
    check("rel.rvalid", 64'(bif.bmem_rvalid), 64'd0);
    check("rel.wc", 64'(bif.write_complete), 64'd0);

    // Back-to-back write then readback
    write_b2b("w40", 32'h0000_0040, 64'h0A, 64'h0B, 64'h0C, 64'h0D);
    read_check("r40", 32'h0000_0040, 1'b0, 32'h0000_0040, 64'h0A, 64'h0B, 64'h0C, 64'h0D);

    // Write beats at cycles 0,2,3,6; later beats carry a bogus address
    bif.bmem_write = 1'b1;
    bif.bmem_addr  = 32'h0000_0080;
    bif.bmem_wdata = 64'h11;
    tick;
    bif.bmem_write = 1'b0;
    bif.bmem_addr  = 32'h0000_01C0;
    check("gap.wc1", 64'(bif.write_complete), 64'd0);
    tick;
    bif.bmem_write = 1'b1;
    bif.bmem_wdata = 64'h22;
    tick;
    bif.bmem_wdata = 64'h33;
    tick;
    bif.bmem_write = 1'b0;
    check("gap.wc4", 64'(bif.write_complete), 64'd0);
    tick;
    check("gap.wc5", 64'(bif.write_complete), 64'd0);
    tick;
    bif.bmem_write = 1'b1;
    bif.bmem_wdata = 64'h44;
    check("gap.ready6", 64'(bif.bmem_ready), 64'd1);
    check("gap.wc6", 64'(bif.write_complete), 64'd0);
    tick;
    bif.bmem_write = 1'b0;
    check("gap.wc7", 64'(bif.write_complete), 64'd1);
    check("gap.ready7", 64'(bif.bmem_ready), 64'd0);
    tick;
    check("gap.wc8", 64'(bif.write_complete), 64'd0);
    read_check("gap.rd", 32'h0000_0080, 1'b0, 32'h0000_0080, 64'h11, 64'h22, 64'h33, 64'h44);
    read_check("gap.l7", 32'h0000_01C0, 1'b0, 32'h0000_01C0,
               pre(14, 0), pre(14, 1), pre(14, 2), pre(14, 3));

    // Aliasing and ignored offset bits
    write_b2b("w800", 32'h0000_0800, 64'h51, 64'h52, 64'h53, 64'h54);
    read_check("alias0", 32'h0000_0000, 1'b0, 32'h0000_0000, 64'h51, 64'h52, 64'h53, 64'h54);
    read_check("alias800", 32'h0000_0800, 1'b0, 32'h0000_0800, 64'h51, 64'h52, 64'h53, 64'h54);
    read_check("off5f", 32'h0000_005F, 1'b0, 32'h0000_0040, 64'h0A, 64'h0B, 64'h0C, 64'h0D);

    // Read and write together: read wins, array untouched
    read_check("both", 32'h0000_00C0, 1'b1, 32'h0000_00C0,
               pre(6, 0), pre(6, 1), pre(6, 2), pre(6, 3));
    read_check("both.after", 32'h0000_00C0, 1'b0, 32'h0000_00C0,
               pre(6, 0), pre(6, 1), pre(6, 2), pre(6, 3));

    // Reset during a read burst, after beat 1
    bif.bmem_read = 1'b1;
    bif.bmem_addr = 32'h0000_0100;
    tick;
    bif.bmem_read = 1'b0;
    tick;
    tick;
    tick;
    check("rrst.b0", bif.bmem_rdata, pre(8, 0));
    tick;
    check("rrst.b1", bif.bmem_rdata, pre(8, 1));
    rst = 1'b0;
    #1;
    check("rrst.rvalid_async", 64'(bif.bmem_rvalid), 64'd0);
    check("rrst.rdata_async", bif.bmem_rdata, 64'd0);
    check("rrst.ready_async", 64'(bif.bmem_ready), 64'd1);
    #2;
    rst = 1'b1;
    tick;
    check("rrst.rvalid_after", 64'(bif.bmem_rvalid), 64'd0);
    check("rrst.ready_after", 64'(bif.bmem_ready), 64'd1);

    // Reset during a write, after beat 2
    bif.bmem_write = 1'b1;
    bif.bmem_addr  = 32'h0000_0100;
    bif.bmem_wdata = 64'h77;
    tick;
    bif.bmem_wdata = 64'h78;
    tick;
    bif.bmem_write = 1'b0;
    rst = 1'b0;
    #1;
    check("wrst.wc_async", 64'(bif.write_complete), 64'd0);
    check("wrst.ready_async", 64'(bif.bmem_ready), 64'd1);
    #2;
    rst = 1'b1;
    tick;
    check("wrst.wc_after", 64'(bif.write_complete), 64'd0);
    tick;
    check("wrst.wc_after2", 64'(bif.write_complete), 64'd0);
    read_check("wrst.rd", 32'h0000_0100, 1'b0, 32'h0000_0100,
               pre(8, 0), pre(8, 1), pre(8, 2), pre(8, 3));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
